shape_plotter: RTL
==================

# shape_plotter

Draw-side consumer for the Mastermind board renderer. It accepts one shape request (base coordinate, shape code, colour), walks every pixel of the shape in raster order, and drives the VGA adapter write port (x, y, colour, plot) at one pixel per clock. It signals completion with a one-cycle `done` pulse. It sits between the game FSM, which issues requests, and the 160x120 VGA adapter.

## Interface
Parameters:
- `SCREEN_W`, 160: visible width in pixels; pixels at x >= SCREEN_W are clipped.
- `SCREEN_H`, 120: visible height in pixels; pixels at y >= SCREEN_H are clipped.

Ports:
- `clock`  in  1  system clock (50 MHz).
- `resetn`  in  1  asynchronous, active-low reset.
- `start`  in  1  request strobe; sampled only when `ready`=1.
- `abort`  in  1  cancel the current draw.
- `base_x`  in  8  top-left x of the shape.
- `base_y`  in  7  top-left y of the shape.
- `shape`  in  2  shape code: 0 = big 20x20; 1 = medium 10x10; 2 = small peg 4x4; 3 = code-row erase 110x20.
- `colour_in`  in  3  fill colour.
- `ready`  out  1  high in IDLE (combinational from state).
- `busy`  out  1  high in DRAW.
- `done`  out  1  one-cycle pulse after the last pixel of an un-aborted draw.
- `x`  out  8  pixel x to the VGA adapter (registered).
- `y`  out  7  pixel y to the VGA adapter (registered).
- `colour`  out  3  pixel colour (registered).
- `plot`  out  1  VGA write enable (registered).

## Operation
- States:
  - IDLE: `ready`=1.
  - DRAW: `busy`=1.
  - DONE: `done`=1 for exactly one cycle, then IDLE.
- Accept: in IDLE, a clock edge with `start`=1 and `abort`=0 does the following:
  - latches `base_x`, `base_y`, `shape` and `colour_in`;
  - clears the column counter `col` (7 bits) and row counter `row` (5 bits);
  - enters DRAW.
- Width and height come from the latched shape: 20/20, 10/10, 4/4, 110/20. Pixel count N is 400, 100, 16 or 2200.
- DRAW, every cycle:
  - register x = base_x+col and y = base_y+row;
  - register colour = latched colour;
  - register plot = 1 only if the 9-bit sum base_x+col < SCREEN_W and the 8-bit sum base_y+row < SCREEN_H;
  - clipped pixels still consume a cycle, with plot=0 and x/y holding the truncated sums;
  - advance `col`; when `col` reaches width-1, clear it and increment `row`;
  - when `col`=width-1 and `row`=height-1, the pixel just issued is the last; enter DONE.
- DONE: `plot`=0, `done`=1, then IDLE. `x`, `y` and `colour` hold their last values.
- Abort: `abort`=1 in DRAW enters IDLE at the next edge with `plot`=0 and no `done` pulse. The pixel issued on that edge is suppressed.
- `abort` in DONE is ignored; `done` still pulses.
- `start` in DRAW or DONE is ignored and is not queued.
- `start`=1 and `abort`=1 together in IDLE: no accept.
- Inputs other than `start`/`abort` are ignored after accept; changing them mid-draw has no effect.

## Timing
- Reset (async, any state, including mid-draw): state IDLE, `x`=0, `y`=0, `colour`=0, `plot`=0, `done`=0, `busy`=0, `ready`=1, counters 0. The pixel in flight is dropped.
- Accept at edge E0: `busy`=1 and pixel 0 (col 0, row 0) is valid on x/y/plot in the cycle after E0.
- Pixel k is presented in cycle k+1 after E0, one pixel per clock with no gaps.
- `done`=1 in cycle N+1 after E0; `ready`=1 from cycle N+2.
- Back-to-back: `start` held high through DONE is accepted at the first IDLE edge. Minimum request spacing is N+2 cycles.
- Raster order is row-major: col 0..width-1 within a row, rows 0..height-1.

## Test plan
- Big square: shape=0, base (10,5), colour=4, one-cycle start:
  - exactly 400 plot cycles, contiguous, starting the cycle after accept;
  - first (10,5), 21st (10,6), last (29,24), colour 4 throughout;
  - `done` high one cycle, 401 cycles after accept.
- Clipping: shape=3, base (100,110):
  - 2200 DRAW cycles, but plot=1 only for x<160 and y<120: 60 columns x 10 rows = 600 writes;
  - `done` still at cycle 2201.
- Abort: shape=1, assert abort during pixel 37:
  - no plot after the edge sampling abort;
  - `done` never pulses; `ready`=1 the next cycle;
  - a new small-peg request afterwards draws 16 pixels correctly.
- Ignored inputs:
  - `start` pulses and base/colour changes during DRAW do not alter output coordinates or colour;
  - start+abort together in IDLE are not accepted (busy stays 0).
- Reset mid-draw: `resetn` low asynchronously at pixel 50 of a big square:
  - plot, busy and done fall immediately without waiting for a clock;
  - after release, `ready`=1, x=0, y=0.
- Back-to-back: `start` held high continuously with shape=2:
  - draws repeat every 18 cycles (16 pixels + DONE + IDLE accept);
  - each draw is followed by exactly one `done` pulse.

Source files
------------

// File: rtl/shape_plotter.sv
// shape_plotter: walks every pixel of one requested shape in raster order and
// drives the VGA adapter write port at one pixel per clock, clipping pixels
// that fall outside the visible screen.
module shape_plotter #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] base_x,
    input  logic [6:0] base_y,
    input  logic [1:0] shape,
    input  logic [2:0] colour_in,
    output logic       ready,
    output logic       busy,
    output logic       done,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DRAW = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [8:0] SCR_W9 = SCREEN_W[8:0];
    localparam logic [7:0] SCR_H8 = SCREEN_H[7:0];

    state_t      state_q,  state_d;
    logic [7:0]  bx_q,     bx_d;
    logic [6:0]  by_q,     by_d;
    logic [1:0]  shp_q,    shp_d;
    logic [2:0]  clr_q,    clr_d;
    logic [6:0]  col_q,    col_d;
    logic [4:0]  row_q,    row_d;
    logic [7:0]  x_q,      x_d;
    logic [6:0]  y_q,      y_d;
    logic [2:0]  colour_q, colour_d;
    logic        plot_q,   plot_d;
    logic [6:0]  col_n_s;
    logic [4:0]  row_n_s;
    logic        last_s;

    // Last column index for a shape code.
    function automatic logic [6:0] col_last(input logic [1:0] s);
        case (s)
            2'd0:    col_last = 7'd19;
            2'd1:    col_last = 7'd9;
            2'd2:    col_last = 7'd3;
            default: col_last = 7'd109;
        endcase
    endfunction

    // Last row index for a shape code.
    function automatic logic [4:0] row_last(input logic [1:0] s);
        case (s)
            2'd0:    row_last = 5'd19;
            2'd1:    row_last = 5'd9;
            2'd2:    row_last = 5'd3;
            default: row_last = 5'd19;
        endcase
    endfunction

    // Visibility test on the untruncated sums so wrapped coordinates are clipped.
    function automatic logic on_screen(input logic [7:0] bx, input logic [6:0] by,
                                       input logic [6:0] c, input logic [4:0] r);
        logic [8:0] sx;
        logic [7:0] sy;
        sx = {1'b0, bx} + {2'b00, c};
        sy = {1'b0, by} + {3'b000, r};
        on_screen = (sx < SCR_W9) && (sy < SCR_H8);
    endfunction

    assign last_s = (col_q == col_last(shp_q)) && (row_q == row_last(shp_q));

    // Next raster position after the pixel currently on the outputs.
    always_comb begin
        col_n_s = col_q;
        row_n_s = row_q;
        if (col_q == col_last(shp_q)) begin
            col_n_s = 7'd0;
            row_n_s = row_q + 5'd1;
        end else begin
            col_n_s = col_q + 7'd1;
            row_n_s = row_q;
        end
    end

    // Next-state and next-output computation; the output registers present
    // the pixel addressed by col_q/row_q while in DRAW.
    always_comb begin
        state_d  = state_q;
        bx_d     = bx_q;
        by_d     = by_q;
        shp_d    = shp_q;
        clr_d    = clr_q;
        col_d    = col_q;
        row_d    = row_q;
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        plot_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    bx_d     = base_x;
                    by_d     = base_y;
                    shp_d    = shape;
                    clr_d    = colour_in;
                    col_d    = 7'd0;
                    row_d    = 5'd0;
                    x_d      = base_x;
                    y_d      = base_y;
                    colour_d = colour_in;
                    plot_d   = on_screen(base_x, base_y, 7'd0, 5'd0);
                    state_d  = S_DRAW;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_DRAW: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (last_s) begin
                    state_d = S_DONE;
                end else begin
                    col_d    = col_n_s;
                    row_d    = row_n_s;
                    x_d      = bx_q + {1'b0, col_n_s};
                    y_d      = by_q + {2'b00, row_n_s};
                    colour_d = clr_q;
                    plot_d   = on_screen(bx_q, by_q, col_n_s, row_n_s);
                    state_d  = S_DRAW;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, request latches, counters and registered pixel outputs.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            bx_q     <= 8'd0;
            by_q     <= 7'd0;
            shp_q    <= 2'd0;
            clr_q    <= 3'd0;
            col_q    <= 7'd0;
            row_q    <= 5'd0;
            x_q      <= 8'd0;
            y_q      <= 7'd0;
            colour_q <= 3'd0;
            plot_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            bx_q     <= bx_d;
            by_q     <= by_d;
            shp_q    <= shp_d;
            clr_q    <= clr_d;
            col_q    <= col_d;
            row_q    <= row_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
        end
    end

    assign ready  = (state_q == S_IDLE);
    assign busy   = (state_q == S_DRAW);
    assign done   = (state_q == S_DONE);
    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;
    assign plot   = plot_q;

endmodule
